// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter that picks one FU completion per cycle and registers it as the broadcast
//   Macro CDB_ARB_ROUND_ROBIN_EN: defined -> round-robin from rr_ptr; undefined -> fixed priority, lowest index wins.
//   Ports: clock, reset (async, active-high), squash_signal (flush);
//          req_valid/req_ready per-FU handshake, req_tag/req_value/req_take_branch/req_npc per-FU payload (FU i at slice i);
//          cdb_valid/cdb_tag/cdb_value/cdb_take_branch/cdb_npc registered one-cycle broadcast.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W = 4,
  parameter int XLEN = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash_signal,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [NUM_REQ*XLEN-1:0]  req_value,
  input  logic [NUM_REQ-1:0]       req_take_branch,
  input  logic [NUM_REQ*XLEN-1:0]  req_npc,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_value,
  output logic                     cdb_take_branch,
  output logic [XLEN-1:0]          cdb_npc
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] sel;
  logic          xfer;
`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
`endif
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int idx;
    idx = 0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
      idx = (int'(rr_ptr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (req_valid[idx]) sel = PW'(idx);
    end
  end
  // sel only names a valid requester when some req_valid is set; reset and squash block every grant.
  assign xfer = |req_valid & ~squash_signal & ~reset;
  assign req_ready = xfer ? (NUM_REQ'(1) << sel) : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_value <= '0;
      cdb_take_branch <= 1'b0;
      cdb_npc <= '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
      rr_ptr <= '0;
`endif
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        cdb_tag <= req_tag[sel*TAG_W +: TAG_W];
        cdb_value <= req_value[sel*XLEN +: XLEN];
        cdb_take_branch <= req_take_branch[sel];
        cdb_npc <= req_npc[sel*XLEN +: XLEN];
`ifdef CDB_ARB_ROUND_ROBIN_EN
        rr_ptr <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (4 FUs, default widths)
module tb_cdb_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         squash_signal = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [15:0]  req_tag = {4'hC, 4'h5, 4'h9, 4'h1};
  logic [127:0] req_value = {32'h4444_3333, 32'hDEAD_BEEF, 32'h2222_1111, 32'h1111_0000};
  logic [3:0]   req_take_branch = 4'b1010;
  logic [127:0] req_npc = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic         cdb_take_branch;
  logic [31:0]  cdb_npc;
  int tests = 0;
  int fails = 0;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .squash_signal(squash_signal),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_value(req_value), .req_take_branch(req_take_branch), .req_npc(req_npc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_take_branch(cdb_take_branch), .cdb_npc(cdb_npc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] tg [4];
    tg[0] = 4'h1; tg[1] = 4'h9; tg[2] = 4'h5; tg[3] = 4'hC;
    // reset held with all requesters asserting
    #2 reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_tag", cdb_tag, 4'h0);
    chk("rst_cdb_value", cdb_value, 32'h0);
    chk("rst_cdb_npc", cdb_npc, 32'h0);
    // first edge after release: FU0 wins
    @(negedge clock) reset = 1'b0;
    #1 chk("rel_ready", req_ready, 4'b0001);
    @(posedge clock) #1;
    chk("rel_cdb_valid", cdb_valid, 1'b1);
    chk("rel_cdb_tag", cdb_tag, 4'h1);
    chk("rel_cdb_value", cdb_value, 32'h1111_0000);
    // single request from FU2
    @(negedge clock) req_valid = 4'b0100;
    #1 chk("fu2_ready", req_ready, 4'b0100);
    @(posedge clock) #1;
    chk("fu2_cdb_valid", cdb_valid, 1'b1);
    chk("fu2_cdb_tag", cdb_tag, 4'h5);
    chk("fu2_cdb_value", cdb_value, 32'hDEAD_BEEF);
    chk("fu2_cdb_br", cdb_take_branch, 1'b0);
    chk("fu2_cdb_npc", cdb_npc, 32'h0000_1008);
    // idle: no grant, valid drops, payload holds
    @(negedge clock) req_valid = 4'b0000;
    #1 chk("idle_ready", req_ready, 4'b0000);
    @(posedge clock) #1;
    chk("idle_cdb_valid", cdb_valid, 1'b0);
    chk("idle_cdb_tag_hold", cdb_tag, 4'h5);
    chk("idle_cdb_value_hold", cdb_value, 32'hDEAD_BEEF);
`ifdef CDB_ARB_ROUND_ROBIN_EN
    // pointer now 3: FU3 beats FU0, then wraps to 0
    @(negedge clock) req_valid = 4'b1001;
    #1 chk("rr_wrap_ready3", req_ready, 4'b1000);
    @(posedge clock) #1 chk("rr_wrap_tag3", cdb_tag, 4'hC);
    @(negedge clock) req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rr_ready_%0d", i), req_ready, 4'b0001 << i);
      @(posedge clock) #1;
      chk($sformatf("rr_cdb_valid_%0d", i), cdb_valid, 1'b1);
      chk($sformatf("rr_cdb_tag_%0d", i), cdb_tag, tg[i]);
      @(negedge clock);
    end
`else
    // fixed priority: FU1 starves FU3 until it drops
    @(negedge clock) req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fp_ready_%0d", i), req_ready, 4'b0010);
      @(posedge clock) #1;
      chk($sformatf("fp_cdb_valid_%0d", i), cdb_valid, 1'b1);
      chk($sformatf("fp_cdb_tag_%0d", i), cdb_tag, tg[1]);
      @(negedge clock);
    end
    req_valid = 4'b1000;
    #1 chk("fp_ready_fu3", req_ready, 4'b1000);
    @(posedge clock) #1 chk("fp_cdb_tag_fu3", cdb_tag, tg[3]);
    @(negedge clock);
`endif
    // squash blocks FU3, then FU3 granted once squash clears
    req_valid = 4'b1000;
    squash_signal = 1'b1;
    #1 chk("sq_ready", req_ready, 4'b0000);
    @(posedge clock) #1 chk("sq_cdb_valid", cdb_valid, 1'b0);
    @(negedge clock) squash_signal = 1'b0;
    #1 chk("sq_rel_ready", req_ready, 4'b1000);
    @(posedge clock) #1;
    chk("sq_rel_cdb_valid", cdb_valid, 1'b1);
    chk("sq_rel_cdb_tag", cdb_tag, 4'hC);
    chk("sq_rel_cdb_value", cdb_value, 32'h4444_3333);
    chk("sq_rel_cdb_br", cdb_take_branch, 1'b1);
    chk("sq_rel_cdb_npc", cdb_npc, 32'h0000_100C);
    // grant FU0 (pointer moves to 1 in RR), then reset mid-cycle
    @(negedge clock) req_valid = 4'b0001;
    @(posedge clock) #1 chk("mid_pre_valid", cdb_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", cdb_valid, 1'b0);
    chk("mid_rst_tag", cdb_tag, 4'h0);
    chk("mid_rst_value", cdb_value, 32'h0);
    chk("mid_rst_br", cdb_take_branch, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    // pending requests proceed after release; pointer back at 0 so FU0 wins
    @(negedge clock) begin
      reset = 1'b0;
      req_valid = 4'b1110;
    end
    #1 chk("post_rst_ready", req_ready, 4'b0010);
    req_valid = 4'b1111;
    #1 chk("post_rst_ready_all", req_ready, 4'b0001);
    @(posedge clock) #1 chk("post_rst_tag", cdb_tag, 4'h1);
    @(negedge clock) req_valid = 4'b0000;
    @(posedge clock) #1 chk("final_idle", cdb_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
